solar_motor_sched: RTL

//  Schedules the four tracker motor drives (N/E/S/W) from the per-direction move requests made by the solar sensor comparator.

---
 rtl/solar_motor_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/solar_motor_sched.sv
// Tracker motor scheduler: one drive at a time, min on-time, dead-time, NS/EW fairness.
// Define SOLAR_SCHED_TIMEOUT_EN to add the MAX_ON run-time limit and sticky fault.
module solar_motor_sched #(
  parameter int CW     = 8,
  parameter int MIN_ON = 4,
  parameter int DEAD   = 3,
  parameter int MAX_ON = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_req_n,
  input  logic i_req_e,
  input  logic i_req_s,
  input  logic i_req_w,
  output logic o_mn,
  output logic o_me,
  output logic o_ms,
  output logic o_mw,
  output logic o_busy,
  output logic o_axis,
  output logic o_fault
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  if (MIN_ON < 1 || DEAD < 1 || MAX_ON < 1) begin : g_param_chk
    $error("solar_motor_sched: MIN_ON, DEAD and MAX_ON must be >= 1");
  end
  if (MIN_ON > (2**CW) - 1 || DEAD > (2**CW) - 1 || MAX_ON > (2**CW) - 1) begin : g_width_chk
    $error("solar_motor_sched: counter width CW too small for parameters");
  end

  localparam logic [CW-1:0] L_MIN_M1  = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] L_DEAD_M1 = CW'(DEAD - 1);
  localparam logic [CW-1:0] L_SAT     = {CW{1'b1}};

  // direction code: bit1 = axis (0 NS, 1 EW), bit0 = second member (s or w)
  state_t        r_state;
  logic [1:0]    r_dir;
  logic [3:0]    r_drv;
  logic [CW-1:0] r_on_cnt;
  logic [CW-1:0] r_dead_cnt;
  logic          r_axis;
  logic          r_busy;

  logic       w_ns_vld;
  logic       w_ew_vld;
  logic       w_any_vld;
  logic       w_grant_ew;
  logic [1:0] w_grant_dir;
  logic       w_held;
  logic       w_other_vld;
  logic       w_min_met;
  logic       w_timeout;
  logic       w_fault_blk;
  logic       w_stop;

  assign w_ns_vld    = i_req_n ^ i_req_s;
  assign w_ew_vld    = i_req_e ^ i_req_w;
  assign w_any_vld   = w_ns_vld | w_ew_vld;
  assign w_grant_ew  = (w_ns_vld & w_ew_vld) ? ~r_axis : w_ew_vld;
  assign w_grant_dir = {w_grant_ew, (w_grant_ew ? i_req_w : i_req_s)};

  assign w_held = r_dir[1] ? (w_ew_vld & (r_dir[0] ? i_req_w : i_req_e))
                           : (w_ns_vld & (r_dir[0] ? i_req_s : i_req_n));
  assign w_other_vld = r_dir[1] ? w_ns_vld : w_ew_vld;
  assign w_min_met   = (r_on_cnt >= L_MIN_M1);

`ifdef SOLAR_SCHED_TIMEOUT_EN
  localparam logic [CW-1:0] L_MAX_M1 = CW'(MAX_ON - 1);
  logic r_fault;

  assign w_timeout   = (r_on_cnt >= L_MAX_M1);
  assign w_fault_blk = r_fault;
  assign o_fault     = r_fault;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fault <= 1'b0;
    end else if (!i_en) begin
      r_fault <= 1'b0;
    end else if (r_state == S_RUN && w_timeout) begin
      r_fault <= 1'b1;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign w_fault_blk = 1'b0;
  assign o_fault     = 1'b0;
`endif

  // en low always wins; after MIN_ON a release, reversal, conflict or rival axis ends the run
  assign w_stop = ~i_en | w_timeout | (w_min_met & (~w_held | w_other_vld));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_dir      <= 2'd0;
      r_drv      <= 4'd0;
      r_on_cnt   <= '0;
      r_dead_cnt <= '0;
      r_axis     <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_en && w_any_vld && !w_fault_blk) begin
            r_state  <= S_RUN;
            r_dir    <= w_grant_dir;
            r_drv    <= 4'b0001 << w_grant_dir;
            r_axis   <= w_grant_ew;
            r_on_cnt <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_stop) begin
            r_state    <= S_DEAD;
            r_drv      <= 4'd0;
            r_dead_cnt <= '0;
          end else if (r_on_cnt != L_SAT) begin
            r_on_cnt <= r_on_cnt + CW'(1);
          end
        end
        S_DEAD: begin
          if (r_dead_cnt == L_DEAD_M1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_dead_cnt <= r_dead_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_drv   <= 4'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_mn   = r_drv[0];
  assign o_ms   = r_drv[1];
  assign o_me   = r_drv[2];
  assign o_mw   = r_drv[3];
  assign o_busy = r_busy;
  assign o_axis = r_axis;

endmodule
